cic3_frame_serializer: RTL and testbench



---
 rtl/echip65_serdes_pkg.sv | 26 ++
 rtl/cic3_frame_serializer_if.sv | 30 +++
 rtl/serdes_lane_shifter.sv | 68 ++++++
 rtl/cic3_frame_serializer.sv | 186 ++++++++++++++++++
 tb/tb_cic3_frame_serializer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/echip65_serdes_pkg.sv
// ---------------------------------------------------------------------------
// echip65_serdes_pkg
// Shared types and constants for the CIC3 frame serializer.
//   state_e              : serializer FSM states
//   SYNC_W_DEFAULT       : default sync header length in bits
//   SYNC_PATTERN_DEFAULT : default sync header value (sent MSB first)
//   frame_len()          : serial frame length in clk cycles
// ---------------------------------------------------------------------------
package echip65_serdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_PARITY
  } state_e;

  localparam int              SYNC_W_DEFAULT       = 8;
  localparam logic [7:0]      SYNC_PATTERN_DEFAULT = 8'hA5;

  // Cycles from the first header bit to the last bit of a lane frame.
  function automatic int frame_len(int cpl, int data_w, bit parity);
    return SYNC_W_DEFAULT + cpl * data_w + (parity ? 1 : 0);
  endfunction

endpackage

// File: rtl/cic3_frame_serializer_if.sv
// ---------------------------------------------------------------------------
// cic3_frame_serializer_if
// Parallel capture side and serial output side of the frame serializer.
//   enable, sclk, din, clr_overrun : driven by the producer (master)
//   sdata, fsync, busy, overrun    : driven by the serializer (slave)
// ---------------------------------------------------------------------------
interface cic3_frame_serializer_if #(
  parameter int NUM_CH    = 12,
  parameter int DATA_W    = 25,
  parameter int NUM_LANES = 4
);
  logic                       enable;
  logic                       sclk;
  logic [NUM_CH*DATA_W-1:0]   din;
  logic                       clr_overrun;
  logic [NUM_LANES-1:0]       sdata;
  logic                       fsync;
  logic                       busy;
  logic                       overrun;

  modport master (
    output enable, sclk, din, clr_overrun,
    input  sdata, fsync, busy, overrun
  );

  modport slave (
    input  enable, sclk, din, clr_overrun,
    output sdata, fsync, busy, overrun
  );
endinterface

// File: rtl/serdes_lane_shifter.sv
// ---------------------------------------------------------------------------
// serdes_lane_shifter
// One serial lane: parallel load of W bits, shift-left on shift_en, MSB out.
// With SERIAL_PARITY_EN defined, also keeps the even parity of every bit
// shifted out since the last load.
//   clk, reset_n : clock, async active-low reset
//   load         : load load_data (has priority over shift_en)
//   shift_en     : shift left by one, zero fill
//   msb          : current MSB of the shift register
//   parity       : (SERIAL_PARITY_EN only) XOR of the bits shifted out
// ---------------------------------------------------------------------------
module serdes_lane_shifter #(
  parameter int W = 75
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
`ifdef SERIAL_PARITY_EN
  output logic         parity,
`endif
  output logic         msb
);

  logic [W-1:0] data_q, data_d;

  // NOTE: every signal assigned in an always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = {data_q[W-2:0], 1'b0};
    end
  end

`ifdef SERIAL_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load) begin
      par_d = 1'b0;
    end else if (shift_en) begin
      par_d = par_q ^ data_q[W-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_q <= 1'b0;
    else          par_q <= par_d;
  end

  assign parity = par_q;
`endif

  // NOTE: state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign msb = data_q[W-1];

endmodule

// File: rtl/cic3_frame_serializer.sv
// ---------------------------------------------------------------------------
// cic3_frame_serializer
// Captures all NUM_CH CIC3 outputs on a rising sclk into a shadow buffer and
// streams them on NUM_LANES serial lanes: SYNC_W header bits (SYNC_PATTERN,
// MSB first) then CPL channels per lane, lowest channel first, MSB first.
// A new capture may overlap transmission (shadow + lane shifters form a
// double buffer); a pending frame follows the current one with no gap.
// Optional feature macro: SERIAL_PARITY_EN adds one even-parity bit per lane
// after the data.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : enable, sclk, din, clr_overrun in; sdata, fsync, busy,
//                  overrun out (all outputs registered)
// ---------------------------------------------------------------------------
module cic3_frame_serializer
  import echip65_serdes_pkg::*;
#(
  parameter int               NUM_CH       = 12,
  parameter int               DATA_W       = 25,
  parameter int               NUM_LANES    = 4,
  parameter int               SYNC_W       = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT
) (
  input logic                    clk,
  input logic                    reset_n,
  cic3_frame_serializer_if.slave bus
);

  localparam int CPL    = NUM_CH / NUM_LANES;
  localparam int LANE_W = CPL * DATA_W;
  localparam int CNT_W  = $clog2(LANE_W > SYNC_W ? LANE_W : SYNC_W);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SYNC_W-1:0]        hdr_q, hdr_d;
  logic [NUM_LANES-1:0]     sdata_q, sdata_d;
  logic                     fsync_q, fsync_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic                     pending_q, pending_d;
  logic                     sclk_q;
  logic [NUM_CH*DATA_W-1:0] shadow_q, shadow_d;

  logic                     capture;
  logic                     load;
  logic                     shift_en;
  logic                     frame_end;
  logic [NUM_LANES-1:0]     lane_msb;
  logic [NUM_LANES-1:0][LANE_W-1:0] lane_word;

  assign capture = bus.sclk & ~sclk_q & bus.enable;

  // Lane l carries channels l*CPL.. l*CPL+CPL-1; the lowest channel goes to
  // the top of the shift word so it leaves first.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar c = 0; c < CPL; c++) begin : g_ch
      assign lane_word[l][(CPL-1-c)*DATA_W +: DATA_W] =
        shadow_q[(l*CPL+c)*DATA_W +: DATA_W];
    end
  end

`ifdef SERIAL_PARITY_EN
  logic [NUM_LANES-1:0] lane_par;
`endif

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_shift
    serdes_lane_shifter #(.W(LANE_W)) u_shift (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .load_data (lane_word[l]),
      .shift_en  (shift_en),
`ifdef SERIAL_PARITY_EN
      .parity    (lane_par[l]),
`endif
      .msb       (lane_msb[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    sdata_d   = sdata_q;
    fsync_d   = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      ST_IDLE: sdata_d = '0;
      ST_HEADER: begin
        if (cnt_q != '0) begin
          sdata_d = {NUM_LANES{hdr_q[SYNC_W-1]}};
          hdr_d   = {hdr_q[SYNC_W-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          state_d  = ST_DATA;
          sdata_d  = lane_msb;
          shift_en = 1'b1;
          cnt_d    = CNT_W'(LANE_W - 1);
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          sdata_d  = lane_msb;
          shift_en = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
`ifdef SERIAL_PARITY_EN
          state_d = ST_PARITY;
          sdata_d = lane_par;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      ST_PARITY: frame_end = 1'b1;
`endif
      default: state_d = ST_IDLE;
    endcase

    if (frame_end) begin
      state_d = ST_IDLE;
      sdata_d = '0;
    end

    // Start (or chain, gap-free) a frame; shifters take the shadow as it
    // stands before this edge, so a same-edge capture is not lost.
    if ((state_q == ST_IDLE || frame_end) && pending_q) begin
      load    = 1'b1;
      state_d = ST_HEADER;
      fsync_d = 1'b1;
      sdata_d = {NUM_LANES{SYNC_PATTERN[SYNC_W-1]}};
      hdr_d   = {SYNC_PATTERN[SYNC_W-2:0], 1'b0};
      cnt_d   = CNT_W'(SYNC_W - 1);
    end

    busy_d = (state_d != ST_IDLE);

    pending_d = pending_q;
    if (load)    pending_d = 1'b0;
    if (capture) pending_d = 1'b1;

    shadow_d = capture ? bus.din : shadow_q;

    // A new overrun event takes precedence over a same-cycle clear.
    overrun_d = overrun_q;
    if (capture && pending_q && !load) overrun_d = 1'b1;
    else if (bus.clr_overrun)          overrun_d = 1'b0;
  end

  // NOTE: the wide shadow buffer is reset along with the control state so
  // the lane shifters never load X after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hdr_q     <= '0;
      sdata_q   <= '0;
      fsync_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
      sclk_q    <= 1'b0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      sdata_q   <= sdata_d;
      fsync_q   <= fsync_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
      sclk_q    <= bus.sclk;
      shadow_q  <= shadow_d;
    end
  end

  assign bus.sdata   = sdata_q;
  assign bus.fsync   = fsync_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_cic3_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_cic3_frame_serializer
// Randomized bench for cic3_frame_serializer. A frame-level reference model
// tracks captures and the frame in flight; the expected lane bit at frame
// position p is derived arithmetically (header / channel / bit / parity).
// ---------------------------------------------------------------------------
module tb_cic3_frame_serializer;

  localparam int NUM_CH    = 12;
  localparam int DATA_W    = 25;
  localparam int NUM_LANES = 4;
  localparam int SYNC_W    = 8;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5;
  localparam int CPL       = NUM_CH / NUM_LANES;
`ifdef SERIAL_PARITY_EN
  localparam int FLEN      = SYNC_W + CPL * DATA_W + 1;
`else
  localparam int FLEN      = SYNC_W + CPL * DATA_W;
`endif

  logic clk = 1'b0;
  logic reset_n;

  cic3_frame_serializer_if #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_LANES(NUM_LANES)
  ) bus ();

  cic3_frame_serializer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_LANES(NUM_LANES),
    .SYNC_W(SYNC_W), .SYNC_PATTERN(SYNC_PATTERN)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic              m_sclk_q, m_pending, m_overrun, m_active;
  int                m_pos;
  logic [DATA_W-1:0] m_shadow [NUM_CH];
  logic [DATA_W-1:0] m_frame  [NUM_CH];

  task automatic model_reset();
    m_sclk_q = 0; m_pending = 0; m_overrun = 0; m_active = 0; m_pos = 0;
  endtask

  task automatic model_edge();
    bit rise, cap, ov;
    rise     = bus.sclk && !m_sclk_q;
    m_sclk_q = bus.sclk;
    cap      = rise && bus.enable;
    if (m_active) begin
      m_pos++;
      if (m_pos == FLEN) m_active = 0;
    end
    if (!m_active && m_pending) begin
      m_active  = 1;
      m_pos     = 0;
      m_frame   = m_shadow;
      m_pending = 0;
    end
    ov = cap && m_pending;
    if (cap) begin
      for (int k = 0; k < NUM_CH; k++) m_shadow[k] = bus.din[k*DATA_W +: DATA_W];
      m_pending = 1;
    end
    if (ov) m_overrun = 1;
    else if (bus.clr_overrun) m_overrun = 0;
  endtask

  function automatic logic lane_bit(int lane, int p);
    logic [SYNC_W-1:0] sp;
    int j;
    logic par;
    sp = SYNC_PATTERN;
    if (p < SYNC_W) return sp[SYNC_W-1-p];
    j = p - SYNC_W;
    if (j < CPL * DATA_W) return m_frame[lane*CPL + j/DATA_W][DATA_W-1 - j%DATA_W];
    par = 0;
    for (int c = 0; c < CPL; c++) par ^= ^m_frame[lane*CPL + c];
    return par;
  endfunction

  function automatic logic [NUM_LANES+2:0] model_out();
    logic [NUM_LANES-1:0] sd;
    sd = '0;
    if (m_active) for (int l = 0; l < NUM_LANES; l++) sd[l] = lane_bit(l, m_pos);
    return {m_active, m_active && (m_pos == 0), m_overrun, sd};
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [NUM_LANES+2:0] dut_out();
    return {bus.busy, bus.fsync, bus.overrun, bus.sdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", 64'(dut_out()), 64'(model_out()));
    if (bus.busy) busy_cycles++;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    bus.sclk = 1'b1;
    tick();
    bus.sclk = 1'b0;
  endtask

  task automatic rand_din();
    for (int k = 0; k < NUM_CH; k++) bus.din[k*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  task automatic reset_mid();
    reset_n = 1'b0;
    #1;
    check("rst_async", 64'(dut_out()), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold", 64'(dut_out()), 64'(0));
    reset_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bool_init: begin
      reset_n = 1'b0;
      bus.enable = 1'b1;
      bus.sclk = 1'b0;
      bus.din = '0;
      bus.clr_overrun = 1'b0;
    end
    model_reset();
    #1;
    check("reset_state", 64'(dut_out()), 64'(0));
    #21 reset_n = 1'b1;

    // Single frame, channel k = 25'h100000 + k.
    for (int k = 0; k < NUM_CH; k++) bus.din[k*DATA_W +: DATA_W] = DATA_W'(32'h100000 + k);
    busy_cycles = 0;
    pulse();
    ticks(100);
    check("single_busy_len", 64'(busy_cycles), 64'(FLEN));

    // Back-to-back: second rise 40 cycles after the first.
    busy_cycles = 0;
    rand_din();
    pulse();
    ticks(39);
    rand_din();
    pulse();
    ticks(2 * FLEN);
    check("b2b_busy_len", 64'(busy_cycles), 64'(2 * FLEN));
    check("b2b_overrun", 64'(bus.overrun), 64'(0));

    // Overrun: three rises 20 cycles apart within one frame.
    rand_din(); pulse(); ticks(19);
    rand_din(); pulse(); ticks(19);
    rand_din(); pulse();
    check("overrun_set", 64'(bus.overrun), 64'(1));
    ticks(2 * FLEN);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    check("overrun_clr", 64'(bus.overrun), 64'(0));

    // enable low: rise ignored; re-enabled rise sends a frame.
    busy_cycles = 0;
    bus.enable = 1'b0;
    rand_din(); pulse(); ticks(100);
    check("disabled_no_frame", 64'(busy_cycles), 64'(0));
    bus.enable = 1'b1;
    rand_din(); pulse(); ticks(100);
    check("reenabled_frame", 64'(busy_cycles), 64'(FLEN));

    // Reset at DATA bit 30, then a clean frame.
    rand_din();
    pulse();
    for (int i = 0; i < 200 && !(m_active && m_pos == SYNC_W + 30); i++) tick();
    check("reached_data_bit30", 64'(m_active && m_pos == SYNC_W + 30), 64'(1));
    reset_mid();
    busy_cycles = 0;
    rand_din(); pulse(); ticks(100);
    check("post_reset_frame", 64'(busy_cycles), 64'(FLEN));

    // Parity pattern on lane 0: channels 1, 3, 0 hold three ones.
    rand_din();
    bus.din[0*DATA_W +: DATA_W] = DATA_W'(1);
    bus.din[1*DATA_W +: DATA_W] = DATA_W'(3);
    bus.din[2*DATA_W +: DATA_W] = DATA_W'(0);
    busy_cycles = 0;
    pulse(); ticks(100);
    check("parity_frame_len", 64'(busy_cycles), 64'(FLEN));

    // Randomized captures, gaps, enable and overrun clears.
    for (int it = 0; it < 200; it++) begin
      int gap;
      gap = $urandom_range(1, 90);
      for (int g = 0; g < gap; g++) begin
        bus.clr_overrun = ($urandom_range(0, 15) == 0);
        tick();
      end
      bus.clr_overrun = 1'b0;
      bus.enable = ($urandom_range(0, 7) != 0);
      rand_din();
      pulse();
    end
    bus.enable = 1'b1;
    ticks(2 * FLEN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
